// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use, branch-operand and control-flow flush
// decisions for a 5-stage MIPS-style pipeline with branches resolved in ID.
module hazard_detection_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in_IF_ID_Rs_address_5,
    input  logic [4:0]  in_IF_ID_Rt_address_5,
    input  logic        in_IF_ID_UsesRs,
    input  logic        in_IF_ID_UsesRt,
    input  logic        in_IF_ID_Branch,
    input  logic        in_Branch_taken,
    input  logic        in_Jump,
    input  logic        in_ID_EX_MemRead,
    input  logic        in_ID_EX_RegWrite,
    input  logic [4:0]  in_ID_EX_Rd_address_5,
    input  logic        in_EX_MEM_MemRead,
    input  logic [4:0]  in_EX_MEM_Rd_address_5,
    output logic        o_PC_write,
    output logic        o_IF_ID_write,
    output logic        o_ID_EX_bubble,
    output logic        o_IF_ID_flush,
    output logic [15:0] o_stall_count_16
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        STALL_EXTRA = 2'd1,
        RELEASE     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;

    logic [4:0] src_addr [2];
    logic [1:0] src_used;
    logic [1:0] ex_match;
    logic [1:0] mem_match;

    logic lu, ba, bl1, bl2, flush_req;
    logic stall, flush;

    assign src_addr[0] = in_IF_ID_Rs_address_5;
    assign src_addr[1] = in_IF_ID_Rt_address_5;
    assign src_used    = {in_IF_ID_UsesRt, in_IF_ID_UsesRs};

    // Writes to $0 are discarded, so a $0 destination never creates a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign ex_match[gi]  = src_used[gi] && (src_addr[gi] == in_ID_EX_Rd_address_5)
                                   && (in_ID_EX_Rd_address_5 != 5'd0);
            assign mem_match[gi] = src_used[gi] && (src_addr[gi] == in_EX_MEM_Rd_address_5)
                                   && (in_EX_MEM_Rd_address_5 != 5'd0);
        end
    endgenerate

    assign lu        = in_ID_EX_MemRead && (|ex_match);
    assign ba        = in_IF_ID_Branch && in_ID_EX_RegWrite && !in_ID_EX_MemRead && (|ex_match);
    assign bl2       = in_IF_ID_Branch && lu;
    assign bl1       = in_IF_ID_Branch && in_EX_MEM_MemRead && (|mem_match);
    assign flush_req = in_Jump || (in_IF_ID_Branch && in_Branch_taken);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                stall = lu || ba || bl1;
                flush = !stall && flush_req;
                if (bl2) begin
                    state_d = STALL_EXTRA;
                end
            end
            STALL_EXTRA: begin
                stall   = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                flush   = flush_req;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Reset is asynchronous, so outputs must return to run values immediately.
        if (reset) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    assign count_d = (stall && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign o_PC_write       = !stall;
    assign o_IF_ID_write    = !stall;
    assign o_ID_EX_bubble   = stall;
    assign o_IF_ID_flush    = flush;
    assign o_stall_count_16 = count_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed pipeline scenarios plus
// random traffic, checked against a cycle-level behavioural model.
module tb_hazard_detection_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs, rt, ex_rd, mem_rd;
    logic        uses_rs, uses_rt, branch, taken, jump;
    logic        ex_memread, ex_regwrite, mem_memread;
    logic        pc_write, ifid_write, bubble, flush;
    logic [15:0] count;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        bubble;
        logic        flush;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q [$];
    int   n_tests;
    int   n_fail;

    // Model state: cycles of unconditional stall still owed, and whether the
    // cycle after them is a forced-release cycle.
    int          m_extra;
    bit          m_release;
    int unsigned m_count;

    hazard_detection_unit dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_IF_ID_Rs_address_5  (rs),
        .in_IF_ID_Rt_address_5  (rt),
        .in_IF_ID_UsesRs        (uses_rs),
        .in_IF_ID_UsesRt        (uses_rt),
        .in_IF_ID_Branch        (branch),
        .in_Branch_taken        (taken),
        .in_Jump                (jump),
        .in_ID_EX_MemRead       (ex_memread),
        .in_ID_EX_RegWrite      (ex_regwrite),
        .in_ID_EX_Rd_address_5  (ex_rd),
        .in_EX_MEM_MemRead      (mem_memread),
        .in_EX_MEM_Rd_address_5 (mem_rd),
        .o_PC_write             (pc_write),
        .o_IF_ID_write          (ifid_write),
        .o_ID_EX_bubble         (bubble),
        .o_IF_ID_flush          (flush),
        .o_stall_count_16       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit depends_on(input logic [4:0] dst);
        return (dst != 0) && ((uses_rs && rs == dst) || (uses_rt && rt == dst));
    endfunction

    // Build the expected outputs for the inputs currently driven, queue them,
    // then advance the model and the clock.
    task automatic step();
        exp_t e;
        bit   st, fl, want_flush, load_use;
        want_flush = jump || (branch && taken);
        st = 0;
        fl = 0;
        if (reset) begin
            m_extra   = 0;
            m_release = 0;
            m_count   = 0;
        end else if (m_extra > 0) begin
            st        = 1;
            m_extra   = m_extra - 1;
            m_release = 1;
        end else if (m_release) begin
            fl        = want_flush;
            m_release = 0;
        end else begin
            load_use = ex_memread && depends_on(ex_rd);
            st = load_use
                 || (branch && ex_regwrite && !ex_memread && depends_on(ex_rd))
                 || (branch && mem_memread && depends_on(mem_rd));
            fl = !st && want_flush;
            if (branch && load_use) m_extra = 1;
        end
        e.pc_write   = !st;
        e.ifid_write = !st;
        e.bubble     = st;
        e.flush      = fl;
        e.count      = 16'(m_count);
        exp_q.push_back(e);
        if (!reset && st && m_count < 32'hFFFF) m_count = m_count + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs = 0; rt = 0; ex_rd = 0; mem_rd = 0;
        uses_rs = 0; uses_rt = 0; branch = 0; taken = 0; jump = 0;
        ex_memread = 0; ex_regwrite = 0; mem_memread = 0;
    endtask

    // Monitor: every cycle the DUT presents a decision; compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{pc_write, ifid_write, bubble, flush, count};
            n_tests++;
            if (a[19:16] != e[19:16]) begin
                n_fail++;
                $display("FAIL ctrl t=%0t got pc=%0b ifid=%0b bub=%0b fl=%0b need pc=%0b ifid=%0b bub=%0b fl=%0b",
                         $time, a.pc_write, a.ifid_write, a.bubble, a.flush,
                         e.pc_write, e.ifid_write, e.bubble, e.flush);
            end
            n_tests++;
            if (a.count != e.count) begin
                n_fail++;
                $display("FAIL count t=%0t got %h need %h", $time, a.count, e.count);
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_extra   = 0;
        m_release = 0;
        m_count   = 0;
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset held with a live load-use hazard: outputs must stay at run values.
        rs = 5'd8; uses_rs = 1; ex_memread = 1; ex_rd = 5'd8; jump = 1;
        step();
        reset = 1'b0;
        idle();
        step();

        // Load-use: lw $8 in EX, add reading $8 in ID.
        rs = 5'd8; uses_rs = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd8;
        step();
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
        step();

        // Branch on a load still in EX: two stalls, then release with taken branch.
        idle();
        branch = 1; rs = 5'd9; rt = 5'd0; uses_rs = 1; uses_rt = 1;
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd9;
        step();
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 5'd9;
        step();
        taken = 1; mem_memread = 0; mem_rd = 0;
        step();
        idle();
        step();

        // Branch on ALU result in EX, then on a load in MEM, then $0 destinations.
        branch = 1; rs = 5'd5; rt = 5'd6; uses_rs = 1; uses_rt = 1;
        ex_regwrite = 1; ex_rd = 5'd5;
        step();
        ex_regwrite = 0; ex_rd = 0; mem_memread = 1; mem_rd = 5'd5;
        step();
        rs = 5'd0; mem_rd = 5'd0; ex_memread = 1; ex_rd = 5'd0;
        step();
        idle();
        step();

        // Jump alongside load-use: stall wins, flush follows once clear.
        jump = 1; rt = 5'd3; uses_rt = 1; ex_memread = 1; ex_rd = 5'd3;
        step();
        ex_memread = 0; ex_rd = 0;
        step();
        idle();

        // Reset in the middle of the extra stall.
        branch = 1; rs = 5'd4; uses_rs = 1; ex_memread = 1; ex_rd = 5'd4;
        step();
        reset = 1;
        step();
        reset = 0;
        step();
        idle();
        step();

        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rs          = 5'($urandom_range(0, 3));
            rt          = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            mem_rd      = 5'($urandom_range(0, 3));
            uses_rs     = 1'($urandom);
            uses_rt     = 1'($urandom);
            branch      = 1'($urandom_range(0, 2) == 0);
            taken       = 1'($urandom);
            jump        = 1'($urandom_range(0, 4) == 0);
            ex_memread  = 1'($urandom);
            ex_regwrite = 1'($urandom);
            mem_memread = 1'($urandom);
            reset       = 1'($urandom_range(0, 60) == 0);
            step();
        end
        reset = 0;

        // Saturation: continuous load-use stalls past 16'hFFFF.
        idle();
        rs = 5'd7; uses_rs = 1; ex_memread = 1; ex_rd = 5'd7;
        for (int i = 0; i < 65540; i++) step();
        idle();
        step();
        step();

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_IF_ID_Rs_address_5  input  5  Rs of the instruction in ID
- in_IF_ID_Rt_address_5  input  5  Rt of the instruction in ID
- in_IF_ID_UsesRs  input  1  instruction in ID reads Rs
- in_IF_ID_UsesRt  input  1  instruction in ID reads Rt
- in_IF_ID_Branch  input  1  instruction in ID is beq/bne, compared in ID
- in_Branch_taken  input  1  ID branch comparator result, valid when in_IF_ID_Branch=1
- in_Jump  input  1  instruction in ID is j/jal/jr
- in_ID_EX_MemRead  input  1  instruction in EX is a load
- in_ID_EX_RegWrite  input  1  instruction in EX writes a register
- in_ID_EX_Rd_address_5  input  5  destination of the instruction in EX, after RegDst selection
- in_EX_MEM_MemRead  input  1  instruction in MEM is a load
- in_EX_MEM_Rd_address_5  input  5  destination of the instruction in MEM
- o_PC_write  output  1  PC enable; 0 holds PC
- o_IF_ID_write  output  1  IF/ID enable; 0 holds IF/ID
- o_ID_EX_bubble  output  1  zeroes ID/EX control fields (inserts a nop)
- o_IF_ID_flush  output  1  clears IF/ID (squashes the fetched instruction)
- o_stall_count_16  output  16  saturating count of stall cycles since reset

Function
REQ-002 A match on port P (Rs or Rt) SHALL require in_IF_ID_UsesP=1, a source address equal to the compared destination, and that destination != 0.
REQ-003 Load-use hazard (LU) SHALL be in_ID_EX_MemRead=1 with a match against in_ID_EX_Rd_address_5.
REQ-004 Branch-ALU hazard (BA) SHALL be in_IF_ID_Branch=1, in_ID_EX_RegWrite=1, in_ID_EX_MemRead=0, with a match against in_ID_EX_Rd_address_5.
REQ-005 Branch-load-EX hazard (BL2) SHALL be in_IF_ID_Branch=1 with LU true.
REQ-006 Branch-load-MEM hazard (BL1) SHALL be in_IF_ID_Branch=1, in_EX_MEM_MemRead=1, with a match against in_EX_MEM_Rd_address_5.
REQ-007 The FSM SHALL have the states RUN, STALL_EXTRA and RELEASE.
REQ-008 In RUN, hz = LU|BA|BL1; hz=1 SHALL drive o_PC_write=0, o_IF_ID_write=0, o_ID_EX_bubble=1, o_IF_ID_flush=0 in the same cycle (combinational).
REQ-009 RUN SHALL go to STALL_EXTRA when BL2=1, otherwise remain in RUN.
REQ-010 STALL_EXTRA SHALL unconditionally assert the stall outputs for one cycle and then go to RELEASE; it SHALL NOT evaluate hazards.
REQ-011 RELEASE SHALL force stall outputs inactive for one cycle, evaluate flush per REQ-012, and then go to RUN.
- Rationale: load data is forwarded to the ID comparator from MEM/WB at this point.
REQ-012 When no stall is asserted, o_IF_ID_flush SHALL equal in_Jump | (in_IF_ID_Branch & in_Branch_taken).
REQ-013 A stall SHALL take priority over a flush; flush=1 and bubble=1 SHALL never be asserted together.
REQ-014 With no stall, o_PC_write=1, o_IF_ID_write=1 and o_ID_EX_bubble=0.
REQ-015 o_stall_count_16 SHALL increment by 1 on each clock edge where o_ID_EX_bubble=1, saturate at 16'hFFFF, and never wrap.
REQ-016 A load with destination $0 SHALL never cause a stall.
REQ-017 BL2 SHALL produce exactly 2 stall cycles, LU/BA/BL1 exactly 1 stall cycle, and back-to-back hazards SHALL re-evaluate in RUN.

Reset
REQ-018 While reset=1 (asynchronous), the state SHALL be RUN and o_stall_count_16 SHALL be 0.
REQ-019 While reset=1, outputs SHALL be forced to o_PC_write=1, o_IF_ID_write=1, o_ID_EX_bubble=0, o_IF_ID_flush=0, regardless of inputs.
REQ-020 A reset asserted in STALL_EXTRA or RELEASE SHALL abort the sequence immediately; after deassertion the FSM SHALL resume in RUN with no residual stall.

Verification
REQ-021 LU: lw $8 in EX, add reading $8 in ID -> 1 cycle with PC_write=0 and bubble=1, then free; count=1.
REQ-022 BL2: lw $9 in EX, beq $9,$0 in ID -> 2 stall cycles, RELEASE, then flush=1 if taken; count=2.
REQ-023 BA: add $5 in EX, bne $5,$6 in ID -> 1 stall; BL1 (lw $5 in MEM) -> 1 stall; $0 destination -> no stall.
REQ-024 Priority: in_Jump=1 together with LU -> bubble=1 and flush=0; next cycle, with the hazard cleared -> flush=1.
REQ-025 Reset mid-STALL_EXTRA -> outputs return to run values without waiting for a clock edge; count=0.
REQ-026 Saturation: preload count to 16'hFFFE, apply 3 stall cycles -> count holds at 16'hFFFF.
